// File: rtl/logic_unit_sliced.sv
// rtl/logic_unit_sliced.sv - multi-cycle bitwise logic unit, SLICE bits per clock
// Operands and op are captured on start; result/zero update only on completion.
module logic_unit_sliced #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inpA,
  input  logic [WIDTH-1:0] inpB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]    idx;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
  logic [SLICE-1:0] a_s, b_s, s_val;
  logic             last;

  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] o,
                                                 input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b);
    case (o)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a;
      default: return b;
    endcase
  endfunction

  always_comb begin
    a_s      = a_q[int'(idx)*SLICE +: SLICE];
    b_s      = b_q[int'(idx)*SLICE +: SLICE];
    s_val    = slice_op(op_q, a_s, b_s);
    last     = (idx == IW'(N - 1));
    // Final slice is forwarded so the result can load on the BUSY->DONE edge.
    acc_next = acc;
    acc_next[int'(idx)*SLICE +: SLICE] = s_val;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_next;
      busy  <= (state_next == BUSY);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= inpA;
            b_q  <= inpB;
            op_q <= op;
            idx  <= '0;
            acc  <= '0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          if (last) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
